regfile_scoreboard: RTL and testbench

Parametrised multi-port integer register file for the pipelined core. Two asynchronous read ports, two synchronous write ports with fixed priority, and a per-register pending (scoreboard) bit that decode sets on issue and writeback clears. Sits between decode (reads, issue) and writeback (writes). Optionally forwards same-cycle write data to the read ports.

---
 rtl/regfile_scoreboard.sv | 102 ++++++++++
 tb/tb_regfile_scoreboard.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Two-read / two-write integer register file with per-register pending bits.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_scoreboard #(
  parameter  int XLEN     = 64,
  parameter  int NREGS    = 32,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            rd1_busy,
  output logic            rd2_busy,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic [XLEN-1:0] wd0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd1,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            flush,
  output logic            any_pending
);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [XLEN-1:0]  mem_d [NREGS];
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Port 1 is applied after port 0 so it wins; issue is applied last so
  // a new producer supersedes a completing one.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (we0 && !is_zero(wa0)) begin
      mem_d[wa0]  = wd0;
      pend_d[wa0] = 1'b0;
    end
    if (we1 && !is_zero(wa1)) begin
      mem_d[wa1]  = wd1;
      pend_d[wa1] = 1'b0;
    end
    if (flush)
      pend_d = '0;
    if (issue_valid && !is_zero(issue_rd))
      pend_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        mem_q[i] <= '0;
      pend_q <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    rd1      = is_zero(rs1) ? '0 : mem_q[rs1];
    rd1_busy = pend_q[rs1];
`ifdef REGFILE_BYPASS_EN
    if (!is_zero(rs1)) begin
      if (we1 && (wa1 == rs1)) begin
        rd1      = wd1;
        rd1_busy = 1'b0;
      end else if (we0 && (wa0 == rs1)) begin
        rd1      = wd0;
        rd1_busy = 1'b0;
      end
    end
`endif
  end

  always_comb begin
    rd2      = is_zero(rs2) ? '0 : mem_q[rs2];
    rd2_busy = pend_q[rs2];
`ifdef REGFILE_BYPASS_EN
    if (!is_zero(rs2)) begin
      if (we1 && (wa1 == rs2)) begin
        rd2      = wd1;
        rd2_busy = 1'b0;
      end else if (we0 && (wa0 == rs2)) begin
        rd2      = wd0;
        rd2_busy = 1'b0;
      end
    end
`endif
  end

  assign any_pending = |pend_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed checks of regfile_scoreboard against a
// behavioural register/pending model.
module tb_regfile_scoreboard;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1, rs2;
  logic [XLEN-1:0] rd1, rd2;
  logic            rd1_busy, rd2_busy;
  logic            we0, we1;
  logic [AW-1:0]   wa0, wa1;
  logic [XLEN-1:0] wd0, wd1;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            flush;
  logic            any_pending;

  int vecs = 0;
  int errs = 0;

  logic [XLEN-1:0] m [NREGS];
  bit              p [NREGS];

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .rs1(rs1), .rs2(rs2),
    .rd1(rd1), .rd2(rd2),
    .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .flush(flush), .any_pending(any_pending)
  );

  always #5 clk = ~clk;

  // Reference: register 0 is hardwired zero and never pending.
  function automatic logic [XLEN-1:0] exp_rd(input int a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we1 && int'(wa1) == a) return wd1;
    if (we0 && int'(wa0) == a) return wd0;
`endif
    return m[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we1 && int'(wa1) == a) return 1'b0;
    if (we0 && int'(wa0) == a) return 1'b0;
`endif
    return p[a];
  endfunction

  function automatic logic exp_any();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += int'(p[i]);
    return n != 0;
  endfunction

  task automatic idle();
    rst = 0; we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
    issue_valid = 0; issue_rd = 0; flush = 0;
  endtask

  // Advance one clock edge, updating the model from the applied inputs.
  task automatic step();
    logic [XLEN-1:0] nm [NREGS];
    bit              np [NREGS];
    nm = m;
    np = p;
    if (rst) begin
      foreach (nm[i]) begin nm[i] = '0; np[i] = 0; end
    end else begin
      if (we0 && wa0 != 0) begin nm[wa0] = wd0; np[wa0] = 0; end
      if (we1 && wa1 != 0) begin nm[wa1] = wd1; np[wa1] = 0; end
      if (flush) foreach (np[i]) np[i] = 0;
      if (issue_valid && issue_rd != 0) np[issue_rd] = 1;
    end
    @(posedge clk);
    #1;
    m = nm;
    p = np;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < NREGS; i++) begin
      rs1 = AW'(i);
      rs2 = AW'(NREGS - 1 - i);
      #1;
      vecs++;
      if (rd1 !== '0 || rd2 !== '0) begin
        errs++;
        $display("FAIL reset_data r%0d: rd1=%h rd2=%h want 0", i, rd1, rd2);
      end
      vecs++;
      if (rd1_busy !== 1'b0 || rd2_busy !== 1'b0 || any_pending !== 1'b0) begin
        errs++;
        $display("FAIL reset_busy r%0d: b1=%b b2=%b any=%b want 0",
                 i, rd1_busy, rd2_busy, any_pending);
      end
    end
  endtask

  task automatic test_zero_reg();
    idle();
    we0 = 1; wa0 = 0; wd0 = 64'hDEAD;
    rs1 = 0;
    #1;
    vecs++;
    if (rd1 !== '0) begin
      errs++;
      $display("FAIL x0_same_cycle: rd1=%h want 0", rd1);
    end
    step();
    idle();
    #1;
    vecs++;
    if (rd1 !== '0) begin
      errs++;
      $display("FAIL x0_write: rd1=%h want 0", rd1);
    end
  endtask

  task automatic test_conflict();
    idle();
    we0 = 1; wa0 = 5; wd0 = 64'h1111;
    we1 = 1; wa1 = 5; wd1 = 64'h2222;
    step();
    idle();
    rs1 = 5;
    #1;
    vecs++;
    if (rd1 !== 64'h2222) begin
      errs++;
      $display("FAIL write_conflict: rd1=%h want 2222", rd1);
    end
  endtask

  task automatic test_issue_write();
    idle();
    issue_valid = 1; issue_rd = 7;
    step();
    idle();
    rs2 = 7;
    #1;
    vecs++;
    if (rd2_busy !== 1'b1 || any_pending !== 1'b1) begin
      errs++;
      $display("FAIL issue_busy: busy=%b any=%b want 1/1", rd2_busy, any_pending);
    end
    we0 = 1; wa0 = 7; wd0 = 64'h42;
    step();
    idle();
    rs2 = 7;
    #1;
    vecs++;
    if (rd2_busy !== 1'b0 || rd2 !== 64'h42 || any_pending !== 1'b0) begin
      errs++;
      $display("FAIL writeback_clear: busy=%b rd2=%h any=%b want 0/42/0",
               rd2_busy, rd2, any_pending);
    end
  endtask

  task automatic test_issue_and_write();
    idle();
    issue_valid = 1; issue_rd = 3;
    we0 = 1; wa0 = 3; wd0 = 64'h9;
    step();
    idle();
    rs1 = 3;
    #1;
    vecs++;
    if (rd1_busy !== 1'b1 || rd1 !== 64'h9) begin
      errs++;
      $display("FAIL issue_wins: busy=%b rd1=%h want 1/9", rd1_busy, rd1);
    end
    we1 = 1; wa1 = 3; wd1 = 64'h9;
    step();
    idle();
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] old;
    idle();
    old = m[10];
    we1 = 1; wa1 = 10; wd1 = 64'hABCD;
    rs1 = 10;
    #1;
    vecs++;
`ifdef REGFILE_BYPASS_EN
    if (rd1 !== 64'hABCD) begin
      errs++;
      $display("FAIL bypass_same: rd1=%h want abcd", rd1);
    end
`else
    if (rd1 !== old) begin
      errs++;
      $display("FAIL no_bypass_same: rd1=%h want %h", rd1, old);
    end
`endif
    step();
    idle();
    rs1 = 10;
    #1;
    vecs++;
    if (rd1 !== 64'hABCD) begin
      errs++;
      $display("FAIL write_visible: rd1=%h want abcd", rd1);
    end
  endtask

  task automatic test_flush();
    int regs [4] = '{1, 2, 4, 8};
    idle();
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1; issue_rd = AW'(regs[i]);
      step();
    end
    idle();
    flush = 1; issue_valid = 1; issue_rd = 8;
    step();
    idle();
    for (int i = 0; i < 4; i++) begin
      rs1 = AW'(regs[i]);
      #1;
      vecs++;
      if (rd1_busy !== (regs[i] == 8)) begin
        errs++;
        $display("FAIL flush_issue r%0d: busy=%b want %b",
                 regs[i], rd1_busy, regs[i] == 8);
      end
    end
  endtask

  task automatic test_reset_midstream();
    idle();
    rst = 1;
    we0 = 1; wa0 = 12; wd0 = 64'h55;
    issue_valid = 1; issue_rd = 13;
    step();
    idle();
    vecs++;
    if (any_pending !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset_pend: any=%b want 0", any_pending);
    end
    for (int i = 0; i < NREGS; i++) begin
      rs1 = AW'(i);
      #1;
      vecs++;
      if (rd1 !== '0 || rd1_busy !== 1'b0) begin
        errs++;
        $display("FAIL mid_reset r%0d: rd1=%h busy=%b want 0/0", i, rd1, rd1_busy);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      idle();
      rst = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 19) == 0);
      we0 = $urandom_range(0, 1) == 1;
      we1 = $urandom_range(0, 2) == 0;
      issue_valid = $urandom_range(0, 1) == 1;
      wa0 = AW'($urandom_range(0, 7));
      wa1 = AW'($urandom_range(0, 7));
      issue_rd = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) wa0 = AW'($urandom);
      wd0 = {$urandom, $urandom};
      wd1 = {$urandom, $urandom};
      rs1 = AW'($urandom_range(0, 8));
      rs2 = AW'($urandom);
      #1;
      vecs++;
      if (rd1 !== exp_rd(rs1) || rd1_busy !== exp_busy(rs1)) begin
        errs++;
        $display("FAIL rand_p1 n%0d rs1=%0d: rd1=%h/%b want %h/%b",
                 n, rs1, rd1, rd1_busy, exp_rd(rs1), exp_busy(rs1));
      end
      vecs++;
      if (rd2 !== exp_rd(rs2) || rd2_busy !== exp_busy(rs2)) begin
        errs++;
        $display("FAIL rand_p2 n%0d rs2=%0d: rd2=%h/%b want %h/%b",
                 n, rs2, rd2, rd2_busy, exp_rd(rs2), exp_busy(rs2));
      end
      vecs++;
      if (any_pending !== exp_any()) begin
        errs++;
        $display("FAIL rand_any n%0d: any=%b want %b", n, any_pending, exp_any());
      end
      step();
    end
  endtask

  initial begin
    idle();
    rs1 = 0;
    rs2 = 0;
    foreach (m[i]) begin m[i] = '0; p[i] = 0; end
    @(negedge clk);
    test_reset();
    test_zero_reg();
    test_conflict();
    test_issue_write();
    test_issue_and_write();
    test_bypass();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
